// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage ahead of the ALU: register file with writeback
// bypass, immediate extension/operand-2 select, and a stallable ID/EX register.
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [IMM_W-1:0]  imm,
    input  logic              alu_src_imm,
    input  logic              imm_zero_ext,
    input  logic [2:0]        alu_ctr_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [2:0]        alu_ctr,
    output logic [DATA_W-1:0] store_data
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    logic [DATA_W-1:0] rs_data_p0;
    logic [DATA_W-1:0] rt_data_p0;
    logic [DATA_W-1:0] op2_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] src1_p1;
    logic [DATA_W-1:0] src2_p1;
    logic [2:0]        ctr_p1;
    logic [DATA_W-1:0] sdata_p1;

    function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] v,
                                                     input logic zext);
        if (zext)
            return {{(DATA_W-IMM_W){1'b0}}, v};
        else
            return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // p0: operand read with same-cycle writeback bypass, operand-2 select
    always_comb begin
        rs_data_p0 = '0;
        if (rs_addr != '0)
            rs_data_p0 = (wr_en && wr_addr == rs_addr) ? wr_data : regs[rs_addr];
    end

    always_comb begin
        rt_data_p0 = '0;
        if (rt_addr != '0)
            rt_data_p0 = (wr_en && wr_addr == rt_addr) ? wr_data : regs[rt_addr];
    end

    always_comb begin
        op2_p0 = alu_src_imm ? extend_imm(imm, imm_zero_ext) : rt_data_p0;
    end

    // p1: ID/EX register; an idle load drops valid but keeps the last operands
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            vld_p1   <= 1'b0;
            src1_p1  <= '0;
            src2_p1  <= '0;
            ctr_p1   <= '0;
            sdata_p1 <= '0;
        end else if (!stall) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                src1_p1  <= rs_data_p0;
                src2_p1  <= op2_p0;
                ctr_p1   <= alu_ctr_in;
                sdata_p1 <= rt_data_p0;
            end
        end
    end

    assign out_valid  = vld_p1;
    assign alu_src1   = src1_p1;
    assign alu_src2   = src2_p1;
    assign alu_ctr    = ctr_p1;
    assign store_data = sdata_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a reference model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [15:0] imm;
    logic        alu_src_imm;
    logic        imm_zero_ext;
    logic [2:0]  alu_ctr_in;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        out_valid;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [2:0]  alu_ctr;
    logic [31:0] store_data;

    int checks = 0;
    int errors = 0;

    alu_operand_stage #(.DATA_W(32), .ADDR_W(5), .IMM_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .alu_src_imm(alu_src_imm),
        .imm_zero_ext(imm_zero_ext), .alu_ctr_in(alu_ctr_in), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(out_valid),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctr(alu_ctr),
        .store_data(store_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register contents plus expected outputs
    logic [31:0] m_rf [32];
    logic        m_vld;
    logic [31:0] m_s1, m_s2, m_sd;
    logic [2:0]  m_ctr;
    bit          model_ok = 0;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] m_ext(input logic [15:0] v, input logic zext);
        int unsigned u;
        u = v;
        if (!zext && u >= 32'h8000) u = u + 32'hFFFF_0000;
        return u;
    endfunction

    always @(posedge clk) begin
        logic [31:0] rs_v, rt_v;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
            m_vld = 0; m_s1 = 0; m_s2 = 0; m_sd = 0; m_ctr = 0;
            model_ok = 1;
        end else begin
            rs_v = m_read(rs_addr);
            rt_v = m_read(rt_addr);
            if (flush) begin
                m_vld = 0; m_s1 = 0; m_s2 = 0; m_sd = 0; m_ctr = 0;
            end else if (!stall) begin
                if (in_valid) begin
                    m_vld = 1;
                    m_s1  = rs_v;
                    m_s2  = alu_src_imm ? m_ext(imm, imm_zero_ext) : rt_v;
                    m_ctr = alu_ctr_in;
                    m_sd  = rt_v;
                end else begin
                    m_vld = 0;
                end
            end
            if (wr_en && wr_addr != 0) m_rf[wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_vld});
            check("cyc_alu_src1", alu_src1, m_s1);
            check("cyc_alu_src2", alu_src2, m_s2);
            check("cyc_alu_ctr", {29'b0, alu_ctr}, {29'b0, m_ctr});
            check("cyc_store_data", store_data, m_sd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1; in_valid = 0; stall = 0; flush = 0;
        rs_addr = 0; rt_addr = 0; imm = 0; alu_src_imm = 0; imm_zero_ext = 0;
        alu_ctr_in = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        step();
        step();

        // Reset clears a previously written register
        idle(); wr_en = 1; wr_addr = 3; wr_data = 32'h1;
        step();
        idle(); rst_n = 0; in_valid = 1; rs_addr = 3;
        step();
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_src1", alu_src1, 32'h0);
        idle(); in_valid = 1; rs_addr = 3;
        step();
        check("post_rst_src1", alu_src1, 32'h0);
        check("post_rst_valid", {31'b0, out_valid}, 32'h1);

        // Write then read
        idle(); wr_en = 1; wr_addr = 5; wr_data = 32'h0000_1234;
        step();
        idle(); in_valid = 1; rs_addr = 5; rt_addr = 0; alu_ctr_in = 3'd5;
        step();
        check("rd_src1", alu_src1, 32'h0000_1234);
        check("rd_src2", alu_src2, 32'h0);
        check("rd_valid", {31'b0, out_valid}, 32'h1);
        check("rd_ctr", {29'b0, alu_ctr}, 32'h5);

        // Same-cycle bypass
        idle(); wr_en = 1; wr_addr = 7; wr_data = 32'hDEAD_BEEF;
        in_valid = 1; rs_addr = 7; rt_addr = 7;
        step();
        check("byp_src1", alu_src1, 32'hDEAD_BEEF);
        check("byp_src2", alu_src2, 32'hDEAD_BEEF);
        check("byp_store", store_data, 32'hDEAD_BEEF);

        // Immediate extension
        idle(); in_valid = 1; rt_addr = 5; imm = 16'h8001; alu_src_imm = 1; imm_zero_ext = 0;
        step();
        check("sext_src2", alu_src2, 32'hFFFF_8001);
        check("sext_store", store_data, 32'h0000_1234);
        imm_zero_ext = 1;
        step();
        check("zext_src2", alu_src2, 32'h0000_8001);

        // Register 0 is hard-wired to zero
        idle(); wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
        step();
        in_valid = 1; rs_addr = 0;
        step();
        check("r0_src1", alu_src1, 32'h0);

        // Stall holds, flush beats stall
        idle(); in_valid = 1; rs_addr = 5; rt_addr = 5;
        step();
        idle(); stall = 1; in_valid = 1; rs_addr = 7; rt_addr = 7;
        step();
        check("stall1_src1", alu_src1, 32'h0000_1234);
        check("stall1_valid", {31'b0, out_valid}, 32'h1);
        step();
        check("stall2_store", store_data, 32'h0000_1234);
        flush = 1;
        step();
        check("flush_valid", {31'b0, out_valid}, 32'h0);
        check("flush_src1", alu_src1, 32'h0);
        check("flush_store", store_data, 32'h0);

        // Idle load drops valid and keeps data
        idle(); in_valid = 1; rs_addr = 7;
        step();
        idle();
        step();
        check("idle_valid", {31'b0, out_valid}, 32'h0);
        check("idle_src1", alu_src1, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            stall        = ($urandom_range(0, 7) == 0);
            flush        = ($urandom_range(0, 15) == 0);
            rs_addr      = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rt_addr      = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            imm          = 16'($urandom);
            alu_src_imm  = 1'($urandom);
            imm_zero_ext = 1'($urandom);
            alu_ctr_in   = 3'($urandom);
            wr_en        = 1'($urandom);
            wr_addr      = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wr_data      = $urandom;
            step();
        end

        idle();
        step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
